// File: rtl/map_scroll_ctrl_if.sv
// Map lookup port, collision lookup handshake and window tile stream of map_scroll_ctrl.
// The master modport is the scheduler side; the slave modport is the map/player/renderer side.
interface map_scroll_ctrl_if;
  logic [99:0] map_y;
  logic [2:0]  map_x;
  logic [2:0]  map_state;
  logic        col_req;
  logic [2:0]  col_lane;
  logic        col_ack;
  logic [2:0]  col_state;
  logic        win_valid;
  logic [2:0]  win_row;
  logic [2:0]  win_lane;
  logic [2:0]  win_state;
  logic        win_done;

  modport master (
    output map_y, map_x, col_ack, col_state,
    output win_valid, win_row, win_lane, win_state, win_done,
    input  map_state, col_req, col_lane
  );

  modport slave (
    input  map_y, map_x, col_ack, col_state,
    input  win_valid, win_row, win_lane, win_state, win_done,
    output map_state, col_req, col_lane
  );
endinterface

// File: rtl/map_scroll_ctrl.sv
// Level scroll position owner and single-port map read scheduler: per-frame window sweep
// into a tile stream, with collision lookups stealing address slots at higher priority.
module map_scroll_ctrl #(
  parameter int ROWS_VIS  = 8,
  parameter int LANES     = 5,
  parameter int SPEED_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              run,
  input  logic              frame_start,
  input  logic [10:0]       map_len,
  output logic [6:0]        scroll_pos,
  output logic              finished,
  map_scroll_ctrl_if.master bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  localparam logic [2:0] LAST_ROW  = 3'(ROWS_VIS - 1);
  localparam logic [2:0] LAST_LANE = 3'(LANES - 1);
  localparam int         FC_W      = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SPEED_DIV - 1);

  function automatic logic [10:0] sat_inc(input logic [10:0] pos, input logic [10:0] len);
    if (len == 11'd0)
      sat_inc = 11'd0;
    else if (pos < len - 11'd1)
      sat_inc = pos + 11'd1;
    else
      sat_inc = pos;
  endfunction

  logic [0:0]      state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [10:0]     scroll_q, scroll_d;
  logic            fin_q, fin_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      lane_q, lane_d;
  logic [11:0]     map_y_q, map_y_d;
  logic [2:0]      map_x_q, map_x_d;

  logic            vld_p0_q, vld_p0_d;
  logic            col_p0_q, col_p0_d;
  logic            last_p0_q, last_p0_d;
  logic            zero_p0_q, zero_p0_d;
  logic [2:0]      row_p0_q, row_p0_d;
  logic [2:0]      lane_p0_q, lane_p0_d;

  logic            col_ack_q, col_ack_d;
  logic [2:0]      col_state_q, col_state_d;
  logic            win_valid_q, win_valid_d;
  logic            win_done_q, win_done_d;
  logic [2:0]      win_row_q, win_row_d;
  logic [2:0]      win_lane_q, win_lane_d;
  logic [2:0]      win_state_q, win_state_d;

  logic            start, sweep_on, col_busy, grant, ent_last;
  logic [2:0]      cur_row, cur_lane;
  logic [11:0]     ent_y;

  always_comb begin
    start    = (state_q == S_IDLE) && frame_start;
    sweep_on = (state_q == S_SWEEP) || start;
    col_busy = (vld_p0_q && col_p0_q) || col_ack_q;
    grant    = bus.col_req && !col_busy;
    cur_row  = (state_q == S_IDLE) ? 3'd0 : row_q;
    cur_lane = (state_q == S_IDLE) ? 3'd0 : lane_q;
    ent_last = (cur_row == LAST_ROW) && (cur_lane == LAST_LANE);

    state_d  = state_q;
    fcnt_d   = fcnt_q;
    scroll_d = scroll_q;
    fin_d    = fin_q;
    row_d    = row_q;
    lane_d   = lane_q;
    map_y_d  = map_y_q;
    map_x_d  = map_x_q;

    // Scroll update happens only on frames that actually launch a sweep.
    if (start && run) begin
      fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
      if (fcnt_d == '0)
        scroll_d = sat_inc(scroll_q, map_len);
      if ((map_len == 11'd0) || (scroll_d == map_len - 11'd1))
        fin_d = 1'b1;
    end

    ent_y = 12'(scroll_d) + 12'(cur_row);

    // Issue stage: at most one address per cycle, collision first.
    vld_p0_d  = 1'b0;
    col_p0_d  = 1'b0;
    last_p0_d = 1'b0;
    zero_p0_d = zero_p0_q;
    row_p0_d  = row_p0_q;
    lane_p0_d = lane_p0_q;

    if (grant) begin
      vld_p0_d  = 1'b1;
      col_p0_d  = 1'b1;
      map_y_d   = 12'(scroll_q);
      map_x_d   = bus.col_lane;
      zero_p0_d = (bus.col_lane > LAST_LANE) || (scroll_q >= map_len);
      if (start) begin
        state_d = S_SWEEP;
        row_d   = 3'd0;
        lane_d  = 3'd0;
      end
    end else if (sweep_on) begin
      vld_p0_d  = 1'b1;
      map_y_d   = ent_y;
      map_x_d   = cur_lane;
      row_p0_d  = cur_row;
      lane_p0_d = cur_lane;
      zero_p0_d = ent_y >= 12'(map_len);
      last_p0_d = ent_last;
      if (ent_last) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_SWEEP;
        if (cur_lane == LAST_LANE) begin
          lane_d = 3'd0;
          row_d  = cur_row + 3'd1;
        end else begin
          lane_d = cur_lane + 3'd1;
          row_d  = cur_row;
        end
      end
    end

    // Result stage: map_state belongs to the address issued last cycle.
    win_valid_d = vld_p0_q && !col_p0_q;
    win_done_d  = win_valid_d && last_p0_q;
    win_row_d   = win_row_q;
    win_lane_d  = win_lane_q;
    win_state_d = win_state_q;
    if (win_valid_d) begin
      win_row_d   = row_p0_q;
      win_lane_d  = lane_p0_q;
      win_state_d = zero_p0_q ? 3'd0 : bus.map_state;
    end

    col_ack_d   = vld_p0_q && col_p0_q;
    col_state_d = col_state_q;
    if (col_ack_d)
      col_state_d = zero_p0_q ? 3'd0 : bus.map_state;

    if (restart) begin
      state_d     = S_IDLE;
      fcnt_d      = '0;
      scroll_d    = 11'd0;
      fin_d       = 1'b0;
      vld_p0_d    = 1'b0;
      win_valid_d = 1'b0;
      win_done_d  = 1'b0;
      col_ack_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      scroll_q    <= 11'd0;
      fin_q       <= 1'b0;
      row_q       <= 3'd0;
      lane_q      <= 3'd0;
      map_y_q     <= 12'd0;
      map_x_q     <= 3'd0;
      vld_p0_q    <= 1'b0;
      col_ack_q   <= 1'b0;
      col_state_q <= 3'd0;
      win_valid_q <= 1'b0;
      win_done_q  <= 1'b0;
      win_row_q   <= 3'd0;
      win_lane_q  <= 3'd0;
      win_state_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      scroll_q    <= scroll_d;
      fin_q       <= fin_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      map_y_q     <= map_y_d;
      map_x_q     <= map_x_d;
      vld_p0_q    <= vld_p0_d;
      col_ack_q   <= col_ack_d;
      col_state_q <= col_state_d;
      win_valid_q <= win_valid_d;
      win_done_q  <= win_done_d;
      win_row_q   <= win_row_d;
      win_lane_q  <= win_lane_d;
      win_state_q <= win_state_d;
    end
  end

  always_ff @(posedge clk) begin
    col_p0_q  <= col_p0_d;
    last_p0_q <= last_p0_d;
    zero_p0_q <= zero_p0_d;
    row_p0_q  <= row_p0_d;
    lane_p0_q <= lane_p0_d;
  end

  assign bus.map_y     = {88'd0, map_y_q};
  assign bus.map_x     = map_x_q;
  assign bus.col_ack   = col_ack_q;
  assign bus.col_state = col_state_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_done  = win_done_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_lane  = win_lane_q;
  assign bus.win_state = win_state_q;
  assign scroll_pos    = scroll_q[6:0];
  assign finished      = fin_q;

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Directed bench for map_scroll_ctrl: a behavioural map ROM answers the address port and a
// negedge monitor records tile, done and collision events for per-sweep checking.
module tb_map_scroll_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        run = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] map_len = 11'd87;
  logic [6:0]  scroll_pos;
  logic        finished;

  map_scroll_ctrl_if bus();

  map_scroll_ctrl #(.ROWS_VIS(8), .LANES(5), .SPEED_DIV(4)) dut (
    .clk(clk), .rst(rst), .restart(restart), .run(run), .frame_start(frame_start),
    .map_len(map_len), .scroll_pos(scroll_pos), .finished(finished), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] tile(input int y, input int x);
    return 3'(((y * 5 + x * 3) % 7) + 1);
  endfunction

  assign bus.map_state = tile(int'(bus.map_y[11:0]), int'(bus.map_x));

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int m_scroll = 0;
  int m_fcnt = 0;
  bit m_fin = 1'b0;

  int         w_cyc[$];
  logic [2:0] w_row[$], w_lane[$], w_st[$];
  int         d_cyc[$];
  int         a_cyc[$];
  logic [2:0] a_st[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.win_valid) begin
      w_cyc.push_back(cyc);
      w_row.push_back(bus.win_row);
      w_lane.push_back(bus.win_lane);
      w_st.push_back(bus.win_state);
    end
    if (bus.win_done) d_cyc.push_back(cyc);
    if (bus.col_ack) begin
      a_cyc.push_back(cyc);
      a_st.push_back(bus.col_state);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    w_cyc.delete(); w_row.delete(); w_lane.delete(); w_st.delete();
    d_cyc.delete(); a_cyc.delete(); a_st.delete();
  endtask

  task automatic mdl_frame(input bit r);
    if (r) begin
      m_fcnt = (m_fcnt + 1) % 4;
      if (m_fcnt == 0 && map_len != 0 && m_scroll < int'(map_len) - 1) m_scroll++;
      if (map_len == 0 || m_scroll == int'(map_len) - 1) m_fin = 1'b1;
    end
  endtask

  task automatic mdl_clear();
    m_scroll = 0;
    m_fcnt = 0;
    m_fin = 1'b0;
  endtask

  function automatic logic [2:0] exp_tile(input int sc, input int r, input int l);
    return (sc + r < int'(map_len)) ? tile(sc + r, l) : 3'd0;
  endfunction

  task automatic frame(input bit r, output int f);
    run = r;
    frame_start = 1'b1;
    f = cyc;
    mdl_frame(r);
    tick();
    frame_start = 1'b0;
  endtask

  // stall: index of the first entry pushed back one cycle by a collision (40 = none)
  task automatic check_sweep(input string tag, input int f, input int sc, input int stall);
    int n;
    check_val({tag, "_cnt"}, 64'(w_cyc.size()), 64'd40);
    n = (w_cyc.size() < 40) ? w_cyc.size() : 40;
    for (int k = 0; k < n; k++) begin
      int r;
      int l;
      int sh;
      r = k / 5;
      l = k % 5;
      sh = (k >= stall) ? 1 : 0;
      check_val({tag, "_tile"},
                64'({16'(w_cyc[k] - f), w_row[k], w_lane[k], w_st[k]}),
                64'({16'(2 + k + sh), 3'(r), 3'(l), exp_tile(sc, r, l)}));
    end
    check_val({tag, "_done"}, 64'((d_cyc.size() == 1) ? d_cyc[0] - f : -1),
              64'(41 + ((stall < 40) ? 1 : 0)));
  endtask

  initial begin
    int f;
    int c;
    bus.col_req = 1'b0;
    bus.col_lane = 3'd0;
    repeat (3) tick();
    rst = 1'b0;

    check_val("rst_win", 64'({bus.win_valid, bus.win_done, bus.win_row, bus.win_lane, bus.win_state}), 64'd0);
    check_val("rst_col", 64'({bus.col_ack, bus.col_state}), 64'd0);
    check_val("rst_map_y0", 64'(bus.map_y == 100'd0), 64'd1);
    check_val("rst_map_x", 64'(bus.map_x), 64'd0);
    check_val("rst_scroll", 64'({scroll_pos, finished}), 64'd0);

    for (int i = 1; i <= 10; i++) begin
      clear_q();
      frame(1'b1, f);
      repeat (45) tick();
      check_sweep("sweep10", f, m_scroll, 40);
    end
    check_val("scroll_after10", 64'(scroll_pos), 64'd2);
    check_val("fin_after10", 64'(finished), 64'd0);

    while (m_scroll < 85) begin
      frame(1'b1, f);
      repeat (41) tick();
    end
    check_val("scroll_85", 64'(scroll_pos), 64'd85);
    check_val("fin_85", 64'(finished), 64'd0);
    while (m_scroll < 86) begin
      frame(1'b1, f);
      repeat (41) tick();
    end
    check_val("scroll_86", 64'(scroll_pos), 64'd86);
    check_val("fin_86", 64'(finished), 64'd1);

    for (int i = 0; i < 5; i++) begin
      clear_q();
      frame(1'b1, f);
      repeat (45) tick();
      check_sweep("sweep_end", f, 86, 40);
      check_val("scroll_sat", 64'({scroll_pos, finished}), 64'({7'd86, 1'b1}));
    end

    clear_q();
    frame(1'b1, f);
    repeat (14) tick();
    bus.col_lane = 3'd2;
    bus.col_req = 1'b1;
    repeat (3) tick();
    bus.col_req = 1'b0;
    repeat (30) tick();
    check_sweep("sweep_col15", f, 86, 15);
    check_val("col15_n", 64'(a_cyc.size()), 64'd1);
    if (a_cyc.size() == 1) begin
      check_val("col15_cyc", 64'(a_cyc[0] - f), 64'd17);
      check_val("col15_state", 64'(a_st[0]), 64'(tile(86, 2)));
    end

    clear_q();
    run = 1'b0;
    bus.col_lane = 3'd1;
    bus.col_req = 1'b1;
    frame_start = 1'b1;
    f = cyc;
    tick();
    frame_start = 1'b0;
    repeat (2) tick();
    bus.col_req = 1'b0;
    repeat (45) tick();
    check_sweep("sweep_colf", f, 86, 0);
    check_val("colf_n", 64'(a_cyc.size()), 64'd1);
    if (a_cyc.size() == 1) begin
      check_val("colf_cyc", 64'(a_cyc[0] - f), 64'd2);
      check_val("colf_state", 64'(a_st[0]), 64'(tile(86, 1)));
    end

    clear_q();
    bus.col_lane = 3'd6;
    bus.col_req = 1'b1;
    c = cyc;
    repeat (3) tick();
    bus.col_req = 1'b0;
    repeat (3) tick();
    check_val("col6_n", 64'(a_cyc.size()), 64'd1);
    if (a_cyc.size() == 1) begin
      check_val("col6_cyc", 64'(a_cyc[0] - c), 64'd2);
      check_val("col6_state", 64'(a_st[0]), 64'd0);
    end

    clear_q();
    frame(1'b1, f);
    repeat (9) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    mdl_clear();
    repeat (40) tick();
    check_val("rs_done", 64'(d_cyc.size()), 64'd0);
    check_val("rs_wvld", 64'(bus.win_valid), 64'd0);
    check_val("rs_scroll", 64'({scroll_pos, finished}), 64'd0);
    clear_q();
    frame(1'b0, f);
    repeat (45) tick();
    check_sweep("sweep_rs", f, 0, 40);

    for (int i = 0; i < 4; i++) begin
      frame(1'b1, f);
      repeat (41) tick();
    end
    check_val("scroll_1", 64'(scroll_pos), 64'd1);

    clear_q();
    frame(1'b1, f);
    repeat (2) tick();
    bus.col_lane = 3'd1;
    bus.col_req = 1'b1;
    repeat (3) tick();
    bus.col_req = 1'b0;
    check_val("pre_rst_col", 64'(bus.col_state), 64'(tile(1, 1)));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_val("mrst_win", 64'({bus.win_valid, bus.win_done, bus.win_row, bus.win_lane, bus.win_state}), 64'd0);
    check_val("mrst_col", 64'({bus.col_ack, bus.col_state}), 64'd0);
    check_val("mrst_map", 64'({bus.map_y == 100'd0, bus.map_x}), 64'({1'b1, 3'd0}));
    check_val("mrst_scroll", 64'({scroll_pos, finished}), 64'd0);
    tick();
    rst = 1'b0;
    mdl_clear();
    tick();

    map_len = 11'd0;
    clear_q();
    frame(1'b1, f);
    repeat (45) tick();
    check_sweep("sweep_len0", f, 0, 40);
    check_val("len0_fin", 64'({scroll_pos, finished}), 64'({7'd0, 1'b1}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/map_scroll_ctrl.md
# map_scroll_ctrl

Scroll and read scheduler for the lane map ROM. Owns the level scroll position, and once per video frame sweeps the visible window of map rows across all five lanes into a tile stream for the renderer. The map lookup has a single address port; the block shares it between that sweep and single-shot collision lookups from player logic, with collision taking priority.

## Interface
Parameters:
- ROWS_VIS, 8: visible window height in map rows.
- LANES, 5: lanes per row; valid lane indices are 0..4.
- SPEED_DIV, 4: frames per one-row scroll advance.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- restart  in  1  synchronous pulse; returns to level start.
- run  in  1  scroll enable, sampled on frame_start.
- frame_start  in  1  one-cycle pulse per video frame.
- map_len  in  11  level length in rows, from the map block.
- map_y  out  100  map row address, registered, zero-extended.
- map_x  out  3  map lane address, registered.
- map_state  in  3  combinational tile state for the current address.
- col_req  in  1  collision lookup request; held until col_ack.
- col_lane  in  3  lane to look up, on the player row.
- col_ack  out  1  one-cycle pulse; col_state is valid.
- col_state  out  3  tile state at (scroll_pos, col_lane).
- win_valid  out  1  win_* carries one window tile.
- win_row  out  3  window row, 0..ROWS_VIS-1.
- win_lane  out  3  lane, 0..LANES-1.
- win_state  out  3  tile state.
- win_done  out  1  pulses with the last tile of a sweep.
- scroll_pos  out  7  current bottom (player) row.
- finished  out  1  sticky; level end reached.

## Operation
- States:
  - IDLE: if frame_start, go to SWEEP.
  - SWEEP: after the last entry is issued, go to IDLE.
- Scroll update, on frame_start while in IDLE with run=1:
  - frame counter increments modulo SPEED_DIV.
  - When the counter wraps to 0, scroll_pos increments, saturating at map_len-1.
  - finished sets when scroll_pos == map_len-1 and holds until rst or restart.
  - map_len == 0: finished sets on the first frame_start and scroll_pos stays 0.
- frame_start with run=0 still triggers a sweep without a scroll update.
- frame_start while in SWEEP is ignored: no scroll update and no queued sweep.
- Sweep contents:
  - ROWS_VIS×LANES entries (default 40), row-major: row 0 first, and lanes 0..4 within each row.
  - Entry (r,l) reads map row scroll_pos+r, using the scroll_pos value after that frame's update.
  - If scroll_pos+r ≥ map_len, the slot is still consumed but win_state is forced to 0.
- Arbitration:
  - Collision has priority. A grant is issued when col_req=1, no collision lookup is in flight, and col_ack is low.
  - A granted collision steals the next address slot; the sweep holds its entry index for that slot.
  - col_lane > 4: the slot is consumed and col_state is forced to 0.
- Collision row: scroll_pos at grant time.
- restart: clears scroll_pos, the frame counter and finished; aborts any sweep (no win_done); drops any in-flight collision (no col_ack); returns to IDLE.
- Reset values: scroll_pos=0, frame counter 0, finished=0, col_ack=0, col_state=0, win_valid=0, win_done=0, win_row=0, win_lane=0, win_state=0, map_y=0, map_x=0; state IDLE.

## Timing
- One address per cycle. An address registered at the edge ending cycle t is presented during t+1. map_state is captured at the end of t+1, and the result outputs are valid in cycle t+2.
- Sweep: frame_start in cycle f → entry 0 address presented in f+1 → first win_valid in f+2.
- An unstalled sweep gives win_valid in f+2..f+41, with win_done in f+41.
- Each collision grant during a sweep adds exactly one cycle.
- Collision: col_req high in cycle c with grant → address presented in c+1 → col_ack and col_state in c+2.
  - The requester drops col_req in the cycle after col_ack. No grant is issued in the col_ack cycle.
- col_req and frame_start in the same IDLE cycle: both are accepted. The collision takes slot f+1 and sweep entry 0 moves to f+2.
- win_* and col_* hold their last values when not valid.

## Test plan
- Reset, then ten frame_start pulses with run=1 and map_len=87 → scroll_pos=2 after frames 4 and 8 give two advances; each sweep has 40 win_valid pulses in consecutive cycles, win_done on the 40th, entries (0,0)..(7,4) in order.
- map_len=87, drive to scroll_pos=86 → finished=1; further frames keep scroll_pos=86; rows 1..7 report win_state=0 while row 0 matches the map.
- col_req with col_lane=2 at cycle 15 of a sweep → col_ack two cycles later with map[scroll_pos][2]; win_done is delayed by exactly 1 cycle, and no tile is skipped or duplicated.
- col_req in the same cycle as frame_start in IDLE → col_ack at f+2; first win_valid at f+3; win_done at f+42.
- col_lane=6 → col_ack with col_state=0 after 2 cycles.
- restart mid-sweep → no win_done, scroll_pos=0, finished=0; the next frame_start sweeps from row 0. rst mid-sweep → all outputs at their reset values on the next cycle.
